// File: rtl/me_full_search_engine.sv
// Full-search block-matching motion estimator: scans every candidate offset
// in a (BLK+2*RANGE)^2 search window, accumulating SAD against a BLKxBLK
// reference block, and reports the best motion vector with a start/completed
// handshake. Optional early exit abandons candidates that cannot win.
module me_full_search_engine #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned BLK        = 16,
  parameter int unsigned RANGE      = 8,
  parameter int unsigned DIST_W     = 16,
  parameter int unsigned EARLY_EXIT = 0,
  localparam int unsigned SWIN      = BLK + 2 * RANGE,
  localparam int unsigned AR_W      = $clog2(BLK * BLK),
  localparam int unsigned AS_W      = $clog2(SWIN * SWIN),
  localparam int unsigned MV_W      = $clog2(2 * RANGE) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [AR_W-1:0]   addr_r,
  input  logic [PIX_W-1:0]  r_data,
  output logic [AS_W-1:0]   addr_s,
  input  logic [PIX_W-1:0]  s_data,
  output logic [MV_W-1:0]   motion_x,
  output logic [MV_W-1:0]   motion_y,
  output logic [DIST_W-1:0] best_dist,
  output logic              completed
);

  localparam int unsigned C_W = $clog2(2 * RANGE);
  localparam int unsigned P_W = $clog2(BLK);
  localparam logic [C_W-1:0] C_MAX = C_W'(2 * RANGE - 1);
  localparam logic [P_W-1:0] P_MAX = P_W'(BLK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t state, state_nx;
  logic   busy_nx;

  // Generator position (next address to issue) and the chosen issue position
  logic [C_W-1:0] gx, gy, ix, iy, gx_nx, gy_nx;
  logic [P_W-1:0] pi, pj, ii, ij, pi_nx, pj_nx;

  // Tags travelling with the address (stage a) and with the returned data (stage b)
  logic           va, fa, la, vb, fb, lb;
  logic [C_W-1:0] xa, ya, xb, yb;

  logic [DIST_W-1:0] acc, best, sad_c;
  logic [C_W-1:0]    bx, by;
  logic [PIX_W-1:0]  diff_c;
  logic [DIST_W:0]   sum_c;
  logic first_cand_b, last_cand_b, take_c, prune_c, fin_c;
  logic issue_c, last_issue_c, run_end_c;

  // Absolute difference, saturating accumulate, compare and prune decisions
  always_comb begin
    diff_c       = (r_data >= s_data) ? (r_data - s_data) : (s_data - r_data);
    sum_c        = (fb ? '0 : {1'b0, acc}) + (DIST_W+1)'(diff_c);
    sad_c        = sum_c[DIST_W] ? '1 : sum_c[DIST_W-1:0];
    first_cand_b = (xb == '0) && (yb == '0);
    last_cand_b  = (xb == C_MAX) && (yb == C_MAX);
    take_c       = vb && lb && (first_cand_b || (sad_c < best));
    prune_c      = (EARLY_EXIT != 0) && vb && !lb && !first_cand_b && (sad_c >= best)
                   && (state == RUN) && (gx == xb) && (gy == yb);
    fin_c        = vb && last_cand_b && (lb || prune_c);
  end

  // Address generator: pick issue position (jump ahead on prune) and advance
  always_comb begin
    ix = gx;
    iy = gy;
    ii = pi;
    ij = pj;
    if (prune_c) begin
      ii = '0;
      ij = '0;
      if (gx == C_MAX) begin
        ix = '0;
        iy = gy + C_W'(1);
      end else begin
        ix = gx + C_W'(1);
      end
    end
    issue_c      = (state == RUN) && !(prune_c && last_cand_b);
    last_issue_c = (ix == C_MAX) && (iy == C_MAX) && (ii == P_MAX) && (ij == P_MAX);
    run_end_c    = (issue_c && last_issue_c) || (prune_c && last_cand_b);
    gx_nx = ix;
    gy_nx = iy;
    pi_nx = ii;
    pj_nx = ij + P_W'(1);
    if (ij == P_MAX) begin
      pj_nx = '0;
      pi_nx = ii + P_W'(1);
      if (ii == P_MAX) begin
        pi_nx = '0;
        gx_nx = ix + C_W'(1);
        if (ix == C_MAX) begin
          gx_nx = '0;
          gy_nx = iy + C_W'(1);
        end
      end
    end
  end

  // Next-state logic; busy stays high through the completed cycle
  always_comb begin
    state_nx = state;
    busy_nx  = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (run_end_c) state_nx = DRAIN;
      DRAIN:   if (completed) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
    end
  end

  // Address registers, generator position and tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx <= '0; gy <= '0; pi <= '0; pj <= '0;
      addr_r <= '0; addr_s <= '0;
      va <= 1'b0; fa <= 1'b0; la <= 1'b0; xa <= '0; ya <= '0;
      vb <= 1'b0; fb <= 1'b0; lb <= 1'b0; xb <= '0; yb <= '0;
    end else begin
      if (state == IDLE) begin
        gx <= '0; gy <= '0; pi <= '0; pj <= '0;
      end else if (issue_c) begin
        gx <= gx_nx; gy <= gy_nx; pi <= pi_nx; pj <= pj_nx;
        addr_r <= AR_W'(32'(ii) * BLK + 32'(ij));
        addr_s <= AS_W'((32'(iy) + 32'(ii)) * SWIN + 32'(ix) + 32'(ij));
      end
      va <= issue_c;
      fa <= (ii == '0) && (ij == '0);
      la <= (ii == P_MAX) && (ij == P_MAX);
      xa <= ix;
      ya <= iy;
      vb <= va && !prune_c;
      fb <= fa;
      lb <= la;
      xb <= xa;
      yb <= ya;
    end
  end

  // Accumulator, running best and published results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      best      <= '1;
      bx        <= '0;
      by        <= '0;
      motion_x  <= '0;
      motion_y  <= '0;
      best_dist <= '1;
      completed <= 1'b0;
    end else begin
      completed <= fin_c;
      if (vb) acc <= sad_c;
      if (take_c) begin
        best <= sad_c;
        bx   <= xb;
        by   <= yb;
      end
      if (fin_c) begin
        best_dist <= take_c ? sad_c : best;
        motion_x  <= MV_W'(take_c ? xb : bx) - MV_W'(RANGE);
        motion_y  <= MV_W'(take_c ? yb : by) - MV_W'(RANGE);
      end
    end
  end

endmodule

// File: tb/tb_me_full_search_engine.sv
// Bench for me_full_search_engine with BLK=4, RANGE=2: directed and random
// searches compared against a plain loop-based full-search reference.
module tb_me_full_search_engine;

  localparam int BLK = 4;
  localparam int RANGE = 2;
  localparam int SWIN = 8;
  localparam int T = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] rmem [16];
  logic [7:0] smem [64];

  logic        start0, start1, start2;
  logic        busy0, busy1, busy2, cp0, cp1, cp2;
  logic [3:0]  ar0, ar1, ar2;
  logic [5:0]  as0, as1, as2;
  logic [7:0]  rd0, rd1, rd2, sd0, sd1, sd2;
  logic [2:0]  mx0, my0, mx1, my1, mx2, my2;
  logic [15:0] bd0, bd1;
  logic [7:0]  bd2;

  me_full_search_engine #(.PIX_W(8), .BLK(BLK), .RANGE(RANGE), .DIST_W(16), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .addr_r(ar0), .r_data(rd0),
    .addr_s(as0), .s_data(sd0), .motion_x(mx0), .motion_y(my0), .best_dist(bd0), .completed(cp0));
  me_full_search_engine #(.PIX_W(8), .BLK(BLK), .RANGE(RANGE), .DIST_W(16), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .addr_r(ar1), .r_data(rd1),
    .addr_s(as1), .s_data(sd1), .motion_x(mx1), .motion_y(my1), .best_dist(bd1), .completed(cp1));
  me_full_search_engine #(.PIX_W(8), .BLK(BLK), .RANGE(RANGE), .DIST_W(8), .EARLY_EXIT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .addr_r(ar2), .r_data(rd2),
    .addr_s(as2), .s_data(sd2), .motion_x(mx2), .motion_y(my2), .best_dist(bd2), .completed(cp2));

  // One-cycle-latency synchronous memories
  always @(posedge clk) begin
    rd0 <= rmem[ar0]; sd0 <= smem[as0];
    rd1 <= rmem[ar1]; sd1 <= smem[as1];
    rd2 <= rmem[ar2]; sd2 <= smem[as2];
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  logic [5:0] as_log [6];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int w);
    case (w) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic logic comp_of(input int w);
    case (w) 0: return cp0; 1: return cp1; default: return cp2; endcase
  endfunction
  function automatic logic [5:0] as_of(input int w);
    case (w) 0: return as0; 1: return as1; default: return as2; endcase
  endfunction
  function automatic int mx_of(input int w);
    case (w) 0: return int'($signed(mx0)); 1: return int'($signed(mx1)); default: return int'($signed(mx2)); endcase
  endfunction
  function automatic int my_of(input int w);
    case (w) 0: return int'($signed(my0)); 1: return int'($signed(my1)); default: return int'($signed(my2)); endcase
  endfunction
  function automatic int bd_of(input int w);
    case (w) 0: return int'(bd0); 1: return int'(bd1); default: return int'(bd2); endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w) 0: start0 = v; 1: start1 = v; default: start2 = v; endcase
  endtask

  // Pulse start on one engine and watch it until shortly after completed
  task automatic run(input int w, output int lat, output int ncomp);
    lat = -1;
    ncomp = 0;
    @(negedge clk);
    set_start(w, 1'b1);
    @(posedge clk);
    #1 set_start(w, 1'b0);
    for (int e = 1; e <= T + 40; e++) begin
      @(posedge clk);
      #1;
      if (e <= 6) as_log[e-1] = as_of(w);
      if (comp_of(w)) begin
        ncomp++;
        if (lat < 0) lat = e;
      end
      if (lat >= 0 && e > lat + 2) break;
    end
  endtask

  // Reference: exhaustive search, saturated SAD, strict-less keeps earliest
  task automatic model(input int dist_w, output int mx, output int my, output int bd);
    int cap, best, sum, d;
    bit have;
    cap = (1 << dist_w) - 1;
    have = 0; best = 0; mx = 0; my = 0;
    for (int dy = 0; dy < 2 * RANGE; dy++)
      for (int dx = 0; dx < 2 * RANGE; dx++) begin
        sum = 0;
        for (int i = 0; i < BLK; i++)
          for (int j = 0; j < BLK; j++) begin
            d = int'(rmem[i*BLK+j]) - int'(smem[(dy+i)*SWIN + dx + j]);
            sum += (d < 0) ? -d : d;
          end
        if (sum > cap) sum = cap;
        if (!have || sum < best) begin
          have = 1; best = sum; mx = dx - RANGE; my = dy - RANGE;
        end
      end
    bd = best;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++) rmem[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 64; k++) smem[k] = 8'($urandom_range(0, 255));
  endtask

  // Distinct search pixels; reference cut from window rows 3..6, cols 1..4
  task automatic fill_tracking();
    bit used [256];
    int v;
    for (int k = 0; k < 256; k++) used[k] = 0;
    for (int k = 0; k < 64; k++) begin
      do v = int'($urandom_range(0, 255)); while (used[v]);
      used[v] = 1;
      smem[k] = 8'(v);
    end
    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++) rmem[i*BLK+j] = smem[(3+i)*SWIN + 1 + j];
  endtask

  initial begin
    int lat, nc, emx, emy, ebd, smx, smy, sbd;
    int exp_as [6] = '{0, 1, 2, 3, 8, 9};

    // Reset with random activity on the inputs
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    fill_random();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start0 = 1'($urandom_range(0, 1));
      start1 = 1'($urandom_range(0, 1));
      start2 = 1'($urandom_range(0, 1));
      fill_random();
    end
    chk("rst_busy", busy0, 0);
    chk("rst_completed", cp0, 0);
    chk("rst_addr_r", ar0, 0);
    chk("rst_addr_s", as0, 0);
    chk("rst_motion_x", mx_of(0), 0);
    chk("rst_motion_y", my_of(0), 0);
    chk("rst_best_dist", bd_of(0), 16'hffff);
    chk("rst_best_dist_d8", bd_of(2), 8'hff);
    chk("rst_busy_ee", busy1, 0);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy0", busy0, 0);
    chk("idle_busy1", busy1, 0);
    chk("idle_busy2", busy2, 0);
    chk("idle_completed", cp0, 0);

    // Tracking pattern
    fill_tracking();
    model(16, emx, emy, ebd);
    run(0, lat, nc);
    chk("track_latency", lat, T + 2);
    chk("track_ncompleted", nc, 1);
    for (int k = 0; k < 6; k++) chk($sformatf("track_addr_s%0d", k), as_log[k], exp_as[k]);
    chk("track_mx", mx_of(0), -1);
    chk("track_my", my_of(0), 1);
    chk("track_bd", bd_of(0), 0);
    chk("track_model_bd", bd_of(0), ebd);

    // Same data with early exit
    run(1, lat, nc);
    chk("ee_early", (lat > 0 && lat < T + 2) ? 1 : 0, 1);
    chk("ee_ncompleted", nc, 1);
    chk("ee_mx", mx_of(1), emx);
    chk("ee_my", my_of(1), emy);
    chk("ee_bd", bd_of(1), ebd);

    // Control: starts while busy, start during/after completed, reset mid-run
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    lat = -1; nc = 0;
    for (int e = 1; e <= T + 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 10 || e == 50) start0 = 1'b1;
      else if (e == 11 || e == 51) start0 = 1'b0;
      if (cp0) begin
        nc++;
        if (lat < 0) begin
          lat = e;
          start0 = 1'b1;
        end
      end else if (lat >= 0 && e == lat + 1) begin
        chk("start_in_completed_ignored", busy0, 0);
      end else if (lat >= 0 && e == lat + 2) begin
        chk("start_after_completed_accepted", busy0, 1);
        start0 = 1'b0;
        break;
      end
    end
    start0 = 1'b0;
    chk("ctl_latency", lat, T + 2);
    chk("ctl_ncompleted", nc, 1);
    chk("ctl_results_held", bd_of(0), 0);
    repeat (99) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy0, 0);
    chk("midrst_completed", cp0, 0);
    chk("midrst_best_dist", bd_of(0), 16'hffff);
    chk("midrst_motion_x", mx_of(0), 0);
    chk("midrst_addr_s", as0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nc = 0;
    for (int e = 0; e < T + 40; e++) begin
      @(posedge clk);
      #1;
      if (cp0) nc++;
    end
    chk("midrst_no_completed", nc, 0);
    chk("midrst_stays_idle", busy0, 0);

    // Tie: every candidate scores zero
    for (int k = 0; k < 16; k++) rmem[k] = 8'd0;
    for (int k = 0; k < 64; k++) smem[k] = 8'd0;
    run(0, lat, nc);
    chk("tie_mx", mx_of(0), -2);
    chk("tie_my", my_of(0), -2);
    chk("tie_bd", bd_of(0), 0);

    // Saturation at DIST_W=8
    for (int k = 0; k < 16; k++) rmem[k] = 8'd255;
    run(2, lat, nc);
    chk("sat_latency", lat, T + 2);
    chk("sat_bd", bd_of(2), 255);
    chk("sat_mx", mx_of(2), -2);
    chk("sat_my", my_of(2), -2);

    // Random windows against the reference on all three engines
    for (int r = 0; r < 3; r++) begin
      fill_random();
      if (r == 2) for (int k = 0; k < 16; k++) rmem[k] = 8'($urandom_range(0, 15));
      if (r == 2) for (int k = 0; k < 64; k++) smem[k] = 8'($urandom_range(0, 15));
      model(16, emx, emy, ebd);
      model(8, smx, smy, sbd);
      run(0, lat, nc);
      chk($sformatf("rnd%0d_lat", r), lat, T + 2);
      chk($sformatf("rnd%0d_mx", r), mx_of(0), emx);
      chk($sformatf("rnd%0d_my", r), my_of(0), emy);
      chk($sformatf("rnd%0d_bd", r), bd_of(0), ebd);
      run(1, lat, nc);
      chk($sformatf("rnd%0d_ee_lat", r), (lat > 0 && lat <= T + 2) ? 1 : 0, 1);
      chk($sformatf("rnd%0d_ee_mx", r), mx_of(1), emx);
      chk($sformatf("rnd%0d_ee_my", r), my_of(1), emy);
      chk($sformatf("rnd%0d_ee_bd", r), bd_of(1), ebd);
      run(2, lat, nc);
      chk($sformatf("rnd%0d_d8_mx", r), mx_of(2), smx);
      chk($sformatf("rnd%0d_d8_my", r), my_of(2), smy);
      chk($sformatf("rnd%0d_d8_bd", r), bd_of(2), sbd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
